// File: rtl/red_stream_acc.sv
// Streaming multi-mode reduction unit: folds every bit of a multi-beat packet into one
// OR/AND/XOR result plus a saturating beat count, with valid/ready on both sides.
module red_stream_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
  input  logic [1:0]       mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_red_o,
  output logic [CNT_W-1:0] out_cnt_o,
  output logic             out_ovf_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_n;
  logic             acc_q, acc_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             ovf_q, ovf_n;
  logic [1:0]       mode_q, mode_n;

  logic             accept;
  logic             first_beat;
  logic [1:0]       eff_mode;
  logic             beat_red;
  logic             fin_acc;
  logic [CNT_W-1:0] fin_cnt;
  logic             fin_ovf;

  // Reserved mode 11 falls into the OR default on purpose.
  function automatic logic reduce_beat(input logic [1:0] m, input logic [WIDTH-1:0] d);
    case (m)
      MODE_AND: reduce_beat = &d;
      MODE_XOR: reduce_beat = ^d;
      default:  reduce_beat = |d;
    endcase
  endfunction

  function automatic logic combine(input logic [1:0] m, input logic a, input logic b);
    case (m)
      MODE_AND: combine = a & b;
      MODE_XOR: combine = a ^ b;
      default:  combine = a | b;
    endcase
  endfunction

  assign in_ready_o = !out_valid_o | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      cnt_q   <= cnt_n;
      ovf_q   <= ovf_n;
      mode_q  <= mode_n;
    end
  end

  // The first beat uses mode_i directly; later beats only see the latched mode.
  always_comb begin
    state_n    = state_q;
    acc_n      = acc_q;
    cnt_n      = cnt_q;
    ovf_n      = ovf_q;
    mode_n     = mode_q;
    first_beat = (state_q == IDLE);
    eff_mode   = first_beat ? mode_i : mode_q;
    beat_red   = reduce_beat(eff_mode, in_data_i);
    fin_acc    = beat_red;
    fin_cnt    = CNT_ONE;
    fin_ovf    = 1'b0;

    if (!first_beat) begin
      fin_acc = combine(mode_q, acc_q, beat_red);
      if (cnt_q == CNT_MAX) begin
        fin_cnt = cnt_q;
        fin_ovf = 1'b1;
      end else begin
        fin_cnt = cnt_q + CNT_ONE;
        fin_ovf = ovf_q;
      end
    end

    if (accept) begin
      if (in_last_i) begin
        state_n = IDLE;
        acc_n   = 1'b0;
        cnt_n   = '0;
        ovf_n   = 1'b0;
        mode_n  = 2'b00;
      end else begin
        state_n = ACCUM;
        acc_n   = fin_acc;
        cnt_n   = fin_cnt;
        ovf_n   = fin_ovf;
        mode_n  = eff_mode;
      end
    end
  end

  // Result register: a new last beat refills it even in the cycle the old result is popped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_red_o   <= 1'b0;
      out_cnt_o   <= '0;
      out_ovf_o   <= 1'b0;
    end else if (accept && in_last_i) begin
      out_valid_o <= 1'b1;
      out_red_o   <= fin_acc;
      out_cnt_o   <= fin_cnt;
      out_ovf_o   <= fin_ovf;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_red_stream_acc.sv
// Directed bench for red_stream_acc (WIDTH=8, CNT_W=2 so saturation is reachable quickly).
module tb_red_stream_acc;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk_i;
  logic             rst_ni;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             in_last_i;
  logic [1:0]       mode_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             out_red_o;
  logic [CNT_W-1:0] out_cnt_o;
  logic             out_ovf_o;

  int assert_count = 0;
  int fail_count   = 0;

  red_stream_acc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .mode_i      (mode_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_red_o   (out_red_o),
    .out_cnt_o   (out_cnt_o),
    .out_ovf_o   (out_ovf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the full output bundle in one go.
  task automatic check_result(input string tag, input logic v, input logic r,
                              input logic [CNT_W-1:0] c, input logic o);
    check_output({tag, ".valid"}, 32'(out_valid_o), 32'(v));
    check_output({tag, ".red"},   32'(out_red_o),   32'(r));
    check_output({tag, ".cnt"},   32'(out_cnt_o),   32'(c));
    check_output({tag, ".ovf"},   32'(out_ovf_o),   32'(o));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] d,
                                input logic l, input logic [1:0] m);
    in_valid_i = v;
    in_data_i  = d;
    in_last_i  = l;
    mode_i     = m;
  endtask

  initial begin
    rst_ni      = 1'b0;
    out_ready_i = 1'b0;
    apply_stimulus(1'b0, 8'h00, 1'b0, 2'b00);
    #2;
    check_result("reset", 1'b0, 1'b0, 2'd0, 1'b0);
    check_output("reset.in_ready", 32'(in_ready_o), 32'd1);
    tick();
    tick();
    rst_ni = 1'b1;

    // 1: OR over three beats
    out_ready_i = 1'b1;
    apply_stimulus(1'b1, 8'h00, 1'b0, 2'b00);
    check_output("t1.in_ready", 32'(in_ready_o), 32'd1);
    tick();
    apply_stimulus(1'b1, 8'h00, 1'b0, 2'b00);
    tick();
    check_output("t1.mid_valid", 32'(out_valid_o), 32'd0);
    apply_stimulus(1'b1, 8'h10, 1'b1, 2'b00);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 2'b00);
    check_result("t1", 1'b1, 1'b1, 2'd3, 1'b0);
    tick();
    check_output("t1.pop", 32'(out_valid_o), 32'd0);

    // 2: AND with mode_i switched mid-packet
    apply_stimulus(1'b1, 8'hFF, 1'b0, 2'b01);
    tick();
    apply_stimulus(1'b1, 8'hFE, 1'b1, 2'b00);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 2'b00);
    check_result("t2", 1'b1, 1'b0, 2'd2, 1'b0);
    tick();
    check_output("t2.pop", 32'(out_valid_o), 32'd0);

    // 3: back-to-back single-beat XOR packets
    apply_stimulus(1'b1, 8'h01, 1'b1, 2'b10);
    tick();
    check_result("t3a", 1'b1, 1'b1, 2'd1, 1'b0);
    apply_stimulus(1'b1, 8'h03, 1'b1, 2'b10);
    check_output("t3.in_ready", 32'(in_ready_o), 32'd1);
    tick();
    check_result("t3b", 1'b1, 1'b0, 2'd1, 1'b0);
    apply_stimulus(1'b1, 8'h07, 1'b1, 2'b10);
    tick();
    check_result("t3c", 1'b1, 1'b1, 2'd1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 2'b00);
    tick();
    check_result("t3.pop", 1'b0, 1'b1, 2'd1, 1'b0);

    // 4: backpressure on the result side
    out_ready_i = 1'b0;
    apply_stimulus(1'b1, 8'h80, 1'b1, 2'b00);
    tick();
    check_result("t4.held", 1'b1, 1'b1, 2'd1, 1'b0);
    apply_stimulus(1'b1, 8'h00, 1'b1, 2'b00);
    check_output("t4.blocked", 32'(in_ready_o), 32'd0);
    tick();
    check_result("t4.stable", 1'b1, 1'b1, 2'd1, 1'b0);
    out_ready_i = 1'b1;
    #1;
    check_output("t4.unblocked", 32'(in_ready_o), 32'd1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 2'b00);
    check_result("t4.new", 1'b1, 1'b0, 2'd1, 1'b0);
    tick();
    check_output("t4.pop", 32'(out_valid_o), 32'd0);

    // 5: count saturation at 3 with sticky overflow
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, (i == 4) ? 8'h01 : 8'h00, (i == 4), 2'b00);
      tick();
    end
    apply_stimulus(1'b1, 8'h00, 1'b1, 2'b00);
    check_result("t5.sat", 1'b1, 1'b1, 2'd3, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 2'b00);
    check_result("t5.next", 1'b1, 1'b0, 2'd1, 1'b0);
    tick();

    // 6: reset in the middle of a packet
    apply_stimulus(1'b1, 8'h01, 1'b0, 2'b10);
    tick();
    apply_stimulus(1'b1, 8'h02, 1'b0, 2'b10);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 2'b00);
    check_output("t6.pre_cnt", 32'(out_cnt_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_result("t6.reset", 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    rst_ni = 1'b1;
    apply_stimulus(1'b1, 8'h01, 1'b1, 2'b10);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 2'b00);
    check_result("t6.fresh", 1'b1, 1'b1, 2'd1, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
